dmem_responder: RTL and testbench

- Data-memory target for the pipeline's memory stage. Serves word load and store requests over a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states per access, so the core and its stall logic can be exercised against non-zero-latency memory.
- Owns the data_memory array. One transaction is outstanding at a time.

---
 rtl/dmem_responder.sv | 192 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the memory stage of the pipeline. It accepts one
// word load or store over a valid/ready request channel and holds off for
// WAIT_CYCLES wait states. It then performs the access and presents the result
// on a valid/ready response channel. Only one transaction is outstanding at a
// time. The block owns the data memory array, and reset does not clear it.
//
// Optional feature: define DMEM_BYTE_EN to add the req_be per-byte write
// enable. Without it, every store writes the full word.
//
// Ports:
//   clk        in   1        clock, all state changes on the rising edge
//   rst        in   1        synchronous active-high reset
//   req_valid  in   1        request present
//   req_ready  out  1        responder can accept a request (IDLE only)
//   req_we     in   1        1 = store, 0 = load
//   req_addr   in   ADDR_W   word address
//   req_wdata  in   DATA_W   store data
//   req_be     in   DATA_W/8 byte write enables (DMEM_BYTE_EN only)
//   rsp_valid  out  1        response present
//   rsp_ready  in   1        requester accepts the response
//   rsp_rdata  out  DATA_W   load data, 0 for stores and errors
//   rsp_err    out  1        address was >= DEPTH
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]      CNT_LOAD = 8'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef DMEM_BYTE_EN
    logic [DATA_W/8-1:0] be_q, be_d;
`endif
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                in_range;
    logic                mem_wr;

    assign idx      = addr_q[IDX_W-1:0];
    assign in_range = ({1'b0, addr_q} < DEPTH_L);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef DMEM_BYTE_EN
        be_d        = be_q;
`endif
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
`ifdef DMEM_BYTE_EN
                    be_d        = req_be;
`endif
                    cnt_d       = CNT_LOAD;
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (!in_range) begin
                        rsp_err_d = 1'b1;
                    end else if (we_q) begin
                        // A reset on the access edge wins, so the store is dropped.
                        mem_wr = !rst;
                    end else begin
                        rsp_rdata_d = mem[idx];
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef DMEM_BYTE_EN
            be_q        <= '0;
`endif
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef DMEM_BYTE_EN
            be_q        <= be_d;
`endif
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory array: never reset, so contents survive rst.
    always_ff @(posedge clk) begin
`ifdef DMEM_BYTE_EN
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (mem_wr && be_q[b]) begin
                mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
`else
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
`endif
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responder instances share one clock and one reset:
//   inst 0: WAIT_CYCLES=2, DEPTH=768
//   inst 1: WAIT_CYCLES=0, DEPTH=1024
//   inst 2: WAIT_CYCLES=4, DEPTH=1024
// Expected responses come from a per-instance memory model. They are pushed to
// a scoreboard queue when a request is accepted, and popped when the response
// arrives.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid   [3];
    logic        req_we      [3];
    logic [9:0]  req_addr    [3];
    logic [31:0] req_wdata   [3];
    logic [3:0]  req_be      [3];
    logic        rsp_ready   [3];
    logic        req_ready_o [3];
    logic        rsp_valid_o [3];
    logic [31:0] rsp_rdata_o [3];
    logic        rsp_err_o   [3];

    logic [31:0] model_mem [3][1024];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(768), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready_o[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_BYTE_EN
        .req_be(req_be[0]),
`endif
        .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata_o[0]), .rsp_err(rsp_err_o[0])
    );

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready_o[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_BYTE_EN
        .req_be(req_be[1]),
`endif
        .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata_o[1]), .rsp_err(rsp_err_o[1])
    );

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready_o[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
`ifdef DMEM_BYTE_EN
        .req_be(req_be[2]),
`endif
        .rsp_valid(rsp_valid_o[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata_o[2]), .rsp_err(rsp_err_o[2])
    );

    function automatic int wait_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 4);
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 768 : 1024;
    endfunction

    // One complete transaction on instance i: accept, wait, check, handshake.
    task automatic txn(input int i, input logic we, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input string tag);
        exp_t        e;
        int          n;
        logic [3:0]  ben;
        ben = be;
`ifndef DMEM_BYTE_EN
        ben = 4'hF;
`endif
        total++;
        if (req_ready_o[i] !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_req: got %b want 1", tag, req_ready_o[i]);
        end
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_be[i]    = be;
        @(posedge clk); #1;
        // Scramble the request inputs; they must not be sampled after accept.
        req_valid[i] = 1'b0;
        req_we[i]    = ~we;
        req_addr[i]  = ~addr;
        req_wdata[i] = ~wdata;
        req_be[i]    = ~be;

        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (int'(addr) >= depth_of(i)) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (ben[b]) model_mem[i][addr][b*8 +: 8] = wdata[b*8 +: 8];
            end
        end else begin
            e.rdata = model_mem[i][addr];
        end
        sb.push_back(e);

        n = 0;
        while (rsp_valid_o[i] !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != wait_of(i) + 1) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles want %0d", tag, n, wait_of(i) + 1);
        end
        e = sb.pop_front();
        total++;
        if (rsp_rdata_o[i] !== e.rdata) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", tag, rsp_rdata_o[i], e.rdata);
        end
        total++;
        if (rsp_err_o[i] !== e.err) begin
            bad++;
            $display("FAIL %s err: got %b want %b", tag, rsp_err_o[i], e.err);
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        total++;
        if (rsp_valid_o[i] !== 1'b0 || req_ready_o[i] !== 1'b1) begin
            bad++;
            $display("FAIL %s after_handshake: got valid=%b ready=%b want valid=0 ready=1",
                     tag, rsp_valid_o[i], req_ready_o[i]);
        end
        total++;
        if (rsp_rdata_o[i] !== e.rdata) begin
            bad++;
            $display("FAIL %s rdata_held: got %h want %h", tag, rsp_rdata_o[i], e.rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (req_ready_o[i] !== 1'b1 || rsp_valid_o[i] !== 1'b0 ||
                rsp_rdata_o[i] !== 32'h0 || rsp_err_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state[%0d]: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                         i, req_ready_o[i], rsp_valid_o[i], rsp_rdata_o[i], rsp_err_o[i]);
            end
        end
    endtask

    task automatic test_wait2();
        txn(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, "w2_store5");
        txn(0, 1'b0, 10'd5, 32'h0,        4'hF, "w2_load5");
    endtask

    task automatic test_wait0();
        txn(1, 1'b1, 10'd5, 32'hCAFEF00D, 4'hF, "w0_store5");
        txn(1, 1'b0, 10'd5, 32'h0,        4'hF, "w0_load5");
        txn(1, 1'b1, 10'd6, 32'h7,        4'hF, "w0_store6");
        txn(1, 1'b0, 10'd6, 32'h0,        4'hF, "w0_load6");
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 10'd5;
        @(posedge clk); #1;
        e.rdata = model_mem[0][5];
        e.err   = 1'b0;
        sb.push_back(e);
        // Keep offering a different request; it must be ignored.
        req_we[0]    = 1'b1;
        req_addr[0]  = 10'd6;
        req_wdata[0] = 32'h0BAD0BAD;
        n = 0;
        while (rsp_valid_o[0] !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rsp_valid_o[0] !== 1'b1 || req_ready_o[0] !== 1'b0 ||
                rsp_rdata_o[0] !== e.rdata || rsp_err_o[0] !== e.err) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b rdata=%h err=%b want 1 0 %h %b",
                         c, rsp_valid_o[0], req_ready_o[0], rsp_rdata_o[0], rsp_err_o[0],
                         e.rdata, e.err);
            end
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        total++;
        if (rsp_valid_o[0] !== 1'b0 || req_ready_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0 1", rsp_valid_o[0], req_ready_o[0]);
        end
        @(posedge clk); #1;
        total++;
        if (req_ready_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_stray_accept: got ready=%b want 1", req_ready_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 10'd5;
        rsp_ready[0] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_valid_o[0] !== ((n % 5) == 4)) begin
                bad++;
                $display("FAIL b2b_valid[%0d]: got %b want %b", n, rsp_valid_o[0], (n % 5) == 4);
            end
            if ((n % 5) == 4) begin
                total++;
                if (rsp_rdata_o[0] !== model_mem[0][5]) begin
                    bad++;
                    $display("FAIL b2b_rdata[%0d]: got %h want %h", n, rsp_rdata_o[0], model_mem[0][5]);
                end
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_range();
        txn(0, 1'b1, 10'd800, 32'h12345678, 4'hF, "oor_store800");
        txn(0, 1'b0, 10'd800, 32'h0,        4'hF, "oor_load800");
        txn(0, 1'b1, 10'd767, 32'h00000767, 4'hF, "edge_store767");
        txn(0, 1'b0, 10'd767, 32'h0,        4'hF, "edge_load767");
    endtask

    task automatic test_reset_mid();
        txn(2, 1'b1, 10'd9, 32'h12345678, 4'hF, "rm_prior_store");
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 10'd9;
        req_wdata[2] = 32'h00000055;
        req_be[2]    = 4'hF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (req_ready_o[2] !== 1'b1 || rsp_valid_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL rm_after_reset: got ready=%b valid=%b want 1 0", req_ready_o[2], rsp_valid_o[2]);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_valid_o[2] !== 1'b0) begin
                bad++;
                $display("FAIL rm_no_rsp[%0d]: got valid=%b want 0", c, rsp_valid_o[2]);
            end
        end
        txn(2, 1'b0, 10'd9, 32'h0, 4'hF, "rm_load9");
    endtask

`ifdef DMEM_BYTE_EN
    task automatic test_byte_en();
        txn(1, 1'b1, 10'd3, 32'h11223344, 4'hF,    "be_init3");
        txn(1, 1'b1, 10'd3, 32'hAABBCCDD, 4'b0101, "be_store_0101");
        txn(1, 1'b0, 10'd3, 32'h0,        4'hF,    "be_load3");
        total++;
        if (model_mem[1][3] !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL be_model: got %h want 11bb33dd", model_mem[1][3]);
        end
        txn(1, 1'b1, 10'd3, 32'hFFFFFFFF, 4'b0000, "be_store_none");
        txn(1, 1'b0, 10'd3, 32'h0,        4'hF,    "be_load3_again");
    endtask
`endif

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            rsp_ready[i] = 1'b0;
        end
        @(posedge clk); #1;
        test_reset();
        test_wait2();
        test_wait0();
        test_backpressure();
        test_back_to_back();
        test_range();
        test_reset_mid();
`ifdef DMEM_BYTE_EN
        test_byte_en();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
